// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter: owner encoding,
// address classes and the address-class helper.
package dmem_pkg;

  localparam int         RAM_WORDS_BIT = 9;
  localparam logic [3:0] MMIO_TAG      = 4'h4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    AC_RAM      = 2'd0,
    AC_MMIO     = 2'd1,
    AC_UNMAPPED = 2'd2
  } addr_class_e;

  // RAM takes precedence so low addresses never alias into the MMIO check.
  function automatic addr_class_e addr_class(input logic [31:0] addr,
                                             input int          ram_words_bit,
                                             input logic [3:0]  mmio_tag);
    if ((addr >> (ram_words_bit + 2)) == 32'd0) return AC_RAM;
    if (addr[31:28] == mmio_tag)                return AC_MMIO;
    return AC_UNMAPPED;
  endfunction

endpackage

// File: rtl/dmem_addr_decode.sv
// Combinational decode of the winning requester's address into RAM / MMIO /
// unmapped, plus a single mapped flag for strobe gating.
module dmem_addr_decode
  import dmem_pkg::*;
#(
  parameter int         RAM_WORDS_BIT = dmem_pkg::RAM_WORDS_BIT,
  parameter logic [3:0] MMIO_TAG      = dmem_pkg::MMIO_TAG
) (
  input  logic [31:0]  addr,
  output addr_class_e  aclass,
  output logic         mapped
);

  assign aclass = addr_class(addr, RAM_WORDS_BIT, MMIO_TAG);
  assign mapped = (aclass != AC_UNMAPPED);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (cpu / dbg) arbiter in front of the single-port data memory:
// locked dbg bursts, starvation guard for dbg, 1-cycle registered read return.
//
//   state    | meaning
//   OWN_NONE | bus idle last cycle; no burst in progress
//   OWN_CPU  | cpu was granted last cycle
//   OWN_DBG  | dbg was granted last cycle; dbg_lock keeps it
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int         ADDR_W        = 32,
  parameter int         DATA_W        = 32,
  parameter int         RAM_WORDS_BIT = dmem_pkg::RAM_WORDS_BIT,
  parameter logic [3:0] MMIO_TAG      = dmem_pkg::MMIO_TAG,
  parameter int         MAX_WAIT      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              err,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] Write_data,
  input  logic [DATA_W-1:0] Read_data
);

  localparam int             CNT_W      = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(MAX_WAIT - 1);

  owner_e            owner, winner;
  logic [CNT_W-1:0]  starve_cnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  addr_class_e       aclass;
  logic              mapped;
  logic              cpu_rd, dbg_rd;
  logic [DATA_W-1:0] rd_data;

  always_ff @(posedge clk) begin
    if (reset) owner <= OWN_NONE;
    else       owner <= winner;
  end

  always_comb begin
    winner = OWN_NONE;
    if (owner == OWN_DBG && dbg_lock && dbg_req) winner = OWN_DBG;
    else if (dbg_req && starve_cnt == STARVE_MAX) winner = OWN_DBG;
    else if (cpu_req)                             winner = OWN_CPU;
    else if (dbg_req)                             winner = OWN_DBG;
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    case (winner)
      OWN_CPU: begin
        sel_we    = cpu_we;
        sel_addr  = cpu_addr;
        sel_wdata = cpu_wdata;
      end
      OWN_DBG: begin
        sel_we    = dbg_we;
        sel_addr  = dbg_addr;
        sel_wdata = dbg_wdata;
      end
      default: ;
    endcase
  end

  dmem_addr_decode #(
    .RAM_WORDS_BIT (RAM_WORDS_BIT),
    .MMIO_TAG      (MMIO_TAG)
  ) u_decode (
    .addr   (sel_addr),
    .aclass (aclass),
    .mapped (mapped)
  );

  assign cpu_gnt    = (winner == OWN_CPU);
  assign dbg_gnt    = (winner == OWN_DBG);
  assign cpu_stall  = cpu_req & ~cpu_gnt;
  assign MemRead    = (winner != OWN_NONE) & ~sel_we;
  assign MemWrite   = sel_we & mapped;
  assign Address    = sel_addr;
  assign Write_data = sel_wdata;

  assign cpu_rd  = cpu_gnt & ~sel_we;
  assign dbg_rd  = dbg_gnt & ~sel_we;
  // Only RAM returns real data; MMIO and unmapped reads answer zero.
  assign rd_data = (aclass == AC_RAM) ? Read_data : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
      err        <= 1'b0;
    end else begin
      if (!dbg_req || dbg_gnt)          starve_cnt <= '0;
      else if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + CNT_W'(1);
      cpu_rvalid <= cpu_rd;
      if (cpu_rd) cpu_rdata <= rd_data;
      dbg_rvalid <= dbg_rd;
      if (dbg_rd) dbg_rdata <= rd_data;
      err <= (winner != OWN_NONE) & ~mapped;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic, all checked
// against a cycle-level reference model of the arbitration and memory rules.
module tb_dmem_arbiter;

  localparam int MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid, err;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic        MemRead, MemWrite;
  logic [31:0] Address, Write_data, Read_data;

  logic [31:0] mem     [512];
  logic [31:0] ref_ram [512];

  int n_vec = 0;
  int n_err = 0;

  int          m_owner;
  int          m_starve;
  logic        e_cpu_rv, e_dbg_rv, e_err;
  logic [31:0] e_cpu_rd, e_dbg_rd;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .err(err), .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address),
    .Write_data(Write_data), .Read_data(Read_data)
  );

  // Memory environment: MMIO returns a junk pattern, out-of-range addresses alias RAM.
  always_comb begin
    if (Address[31:28] == 4'h4) Read_data = 32'hDEAD_BEEF;
    else                        Read_data = mem[Address[10:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic c_req, input logic c_we, input logic [31:0] c_addr,
                       input logic [31:0] c_wd, input logic d_req, input logic d_we,
                       input logic [31:0] d_addr, input logic [31:0] d_wd, input logic lock);
    cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
    dbg_req = d_req; dbg_we = d_we; dbg_addr = d_addr; dbg_wdata = d_wd;
    dbg_lock = lock;
  endtask

  task automatic idle();
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
  endtask

  // One clock cycle: check everything against the model, advance the model,
  // then let the memory environment commit any write seen this cycle.
  task automatic cycle();
    int          win;
    logic        we, is_ram, is_map, do_wr;
    logic [31:0] a, wd, wr_a, wr_d;
    #1;
    if (m_owner == 2 && dbg_lock && dbg_req)       win = 2;
    else if (dbg_req && m_starve == MAX_WAIT - 1)  win = 2;
    else if (cpu_req)                              win = 1;
    else if (dbg_req)                              win = 2;
    else                                           win = 0;
    we = (win == 1) ? cpu_we : (win == 2) ? dbg_we : 1'b0;
    a  = (win == 1) ? cpu_addr : (win == 2) ? dbg_addr : 32'h0;
    wd = (win == 1) ? cpu_wdata : (win == 2) ? dbg_wdata : 32'h0;
    is_ram = (a < 32'd2048);
    is_map = is_ram || (a[31:28] == 4'h4);

    chk("cpu_gnt",    {31'd0, cpu_gnt},   {31'd0, win == 1});
    chk("dbg_gnt",    {31'd0, dbg_gnt},   {31'd0, win == 2});
    chk("cpu_stall",  {31'd0, cpu_stall}, {31'd0, cpu_req && win != 1});
    chk("MemRead",    {31'd0, MemRead},   {31'd0, win != 0 && !we});
    chk("MemWrite",   {31'd0, MemWrite},  {31'd0, win != 0 && we && is_map});
    chk("Address",    Address, a);
    chk("Write_data", Write_data, wd);
    chk("cpu_rvalid", {31'd0, cpu_rvalid}, {31'd0, e_cpu_rv});
    chk("cpu_rdata",  cpu_rdata, e_cpu_rd);
    chk("dbg_rvalid", {31'd0, dbg_rvalid}, {31'd0, e_dbg_rv});
    chk("dbg_rdata",  dbg_rdata, e_dbg_rd);
    chk("err",        {31'd0, err}, {31'd0, e_err});

    do_wr = MemWrite && (Address < 32'd2048);
    wr_a  = Address;
    wr_d  = Write_data;

    if (reset) begin
      e_cpu_rv = 0; e_dbg_rv = 0; e_err = 0;
      e_cpu_rd = 0; e_dbg_rd = 0;
      m_owner  = 0; m_starve = 0;
    end else begin
      e_cpu_rv = (win == 1) && !we;
      e_dbg_rv = (win == 2) && !we;
      if (e_cpu_rv) e_cpu_rd = is_ram ? ref_ram[a[10:2]] : 32'h0;
      if (e_dbg_rv) e_dbg_rd = is_ram ? ref_ram[a[10:2]] : 32'h0;
      e_err    = (win != 0) && !is_map;
      m_owner  = win;
      if (!dbg_req || win == 2)         m_starve = 0;
      else if (m_starve < MAX_WAIT - 1) m_starve = m_starve + 1;
    end
    if (win != 0 && we && is_ram) ref_ram[a[10:2]] = wd;

    @(posedge clk);
    #1;
    if (do_wr) mem[wr_a[10:2]] = wr_d;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 6)       return {21'd0, 9'($urandom_range(0, 511)), 2'b00};
    else if (r < 8)  return 32'h4000_0000 | {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
    else if (r == 8) return 32'h0000_1000 + {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    else             return 32'h8000_0000 | 32'($urandom());
  endfunction

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem[i]     = $urandom();
      ref_ram[i] = mem[i];
    end
    mem[0] = 32'h1234_5678; ref_ram[0] = 32'h1234_5678;
    mem[2] = 32'h0000_0009; ref_ram[2] = 32'h0000_0009;
    m_owner = 0; m_starve = 0;
    e_cpu_rv = 0; e_dbg_rv = 0; e_err = 0; e_cpu_rd = 0; e_dbg_rd = 0;

    reset = 1'b1;
    idle();
    @(posedge clk);
    #1;
    cycle();
    reset = 1'b0;
    cycle();

    // single cpu read of RAM word 2
    drive(1, 0, 32'h8, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    #1;
    chk("tp1_gnt", {31'd0, cpu_gnt}, 32'd1);
    chk("tp1_memread", {31'd0, MemRead}, 32'd1);
    chk("tp1_addr", Address, 32'h8);
    cycle();
    chk("tp1_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    chk("tp1_rdata", cpu_rdata, 32'h9);

    // contention: dbg wins only when it has waited MAX_WAIT-1 cycles
    idle(); cycle();
    for (int k = 0; k < 10; k++) begin
      drive(1, 0, 32'h10, 32'h0, 1, 0, 32'h20, 32'h0, 0);
      #1;
      chk("starve_dbg_gnt", {31'd0, dbg_gnt}, {31'd0, k == MAX_WAIT - 1});
      chk("starve_stall", {31'd0, cpu_stall}, {31'd0, k == MAX_WAIT - 1});
      cycle();
    end

    // locked dbg write burst, entered through the starvation grant
    idle(); cycle();
    for (int k = 0; k < MAX_WAIT - 1; k++) begin
      drive(1, 0, 32'h0, 32'h0, 1, 1, 32'h100, 32'hA000, 1);
      cycle();
    end
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 32'h0, 32'h0, 1, 1, 32'h100 + 32'(4 * k), 32'hA000 + 32'(k), 1);
      #1;
      chk("burst_dbg_gnt", {31'd0, dbg_gnt}, 32'd1);
      chk("burst_memwrite", {31'd0, MemWrite}, 32'd1);
      chk("burst_stall", {31'd0, cpu_stall}, 32'd1);
      cycle();
    end
    drive(1, 0, 32'h104, 32'h0, 0, 0, 32'h0, 32'h0, 1);
    #1;
    chk("after_burst_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
    cycle();
    chk("burst_readback", cpu_rdata, 32'hA001);

    // MMIO write then read
    drive(1, 1, 32'h4000_0000, 32'h123, 0, 0, 32'h0, 32'h0, 0);
    #1;
    chk("mmio_memwrite", {31'd0, MemWrite}, 32'd1);
    chk("mmio_addr", Address, 32'h4000_0000);
    cycle();
    chk("mmio_err", {31'd0, err}, 32'd0);
    drive(1, 0, 32'h4000_0000, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    cycle();
    chk("mmio_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    chk("mmio_rdata", cpu_rdata, 32'h0);

    // unmapped write then read
    drive(1, 1, 32'h0000_1000, 32'h55, 0, 0, 32'h0, 32'h0, 0);
    #1;
    chk("unmap_gnt", {31'd0, cpu_gnt}, 32'd1);
    chk("unmap_memwrite", {31'd0, MemWrite}, 32'd0);
    cycle();
    chk("unmap_err", {31'd0, err}, 32'd1);
    idle(); cycle();
    chk("unmap_err_pulse", {31'd0, err}, 32'd0);
    drive(1, 0, 32'h0000_1000, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    cycle();
    chk("unmap_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    chk("unmap_rdata", cpu_rdata, 32'h0);

    // reset lands on a granted, locked dbg read
    idle(); cycle();
    drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h8, 32'h0, 1);
    cycle();
    reset = 1'b1;
    #1;
    chk("rst_dbg_gnt", {31'd0, dbg_gnt}, 32'd1);
    cycle();
    reset = 1'b0;
    drive(1, 0, 32'h4, 32'h0, 1, 0, 32'hC, 32'h0, 1);
    #1;
    chk("rst_no_rvalid", {31'd0, dbg_rvalid}, 32'd0);
    chk("rst_dbg_rdata", dbg_rdata, 32'h0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_owner_none", {31'd0, cpu_gnt}, 32'd1);
    cycle();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), rand_addr(), $urandom(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), $urandom(),
            $urandom_range(0, 3) != 0);
      cycle();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
